// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment glyphs, decoder function and counter width default
package seven_seg_pkg;
  localparam int COUNT_W_DEF = 24;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment order {g,f,e,d,c,b,a}; values 10-15 never occur and blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: seg_decode = SEG_0;
      4'd1: seg_decode = SEG_1;
      4'd2: seg_decode = SEG_2;
      4'd3: seg_decode = SEG_3;
      4'd4: seg_decode = SEG_4;
      4'd5: seg_decode = SEG_5;
      4'd6: seg_decode = SEG_6;
      4'd7: seg_decode = SEG_7;
      4'd8: seg_decode = SEG_8;
      4'd9: seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: combinational digit to common-cathode segment pattern
//   digit    in  4  decimal value 0-9
//   segments out 7  {g,f,e,d,c,b,a}, 1 = lit
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);
  assign segments = seg_decode(digit);
endmodule

// File: rtl/seven_segment_seconds.sv
// seven_segment_seconds: prescaled 0-9 seconds counter driving one seven-segment digit
//   clk          in  1        user clock, rising edge
//   reset_n      in  1        synchronous active-low reset
//   compare_in   in  COUNT_W  new prescaler compare value
//   compare_load in  1        capture compare_in and restart the period
//   led_out      out 7        segments {g,f,e,d,c,b,a}
//   led_oeb      out 7        pad output-enable bar, always driven low
//   digit        out 4        current decimal value
module seven_segment_seconds
  import seven_seg_pkg::*;
#(
  parameter int                  COUNT_W         = COUNT_W_DEF,
  parameter logic [COUNT_W-1:0]  DEFAULT_COMPARE = 24'd15_999_999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COUNT_W-1:0] compare_in,
  input  logic               compare_load,
  output logic [6:0]         led_out,
  output logic [6:0]         led_oeb,
  output logic [3:0]         digit
);
  logic [COUNT_W-1:0] compare;
  logic [COUNT_W-1:0] sec_cnt;

  // >= rather than == so a count left above a freshly shrunk compare wraps at once.
  always_ff @(posedge clk)
    if (!reset_n) begin
      compare <= DEFAULT_COMPARE;
      sec_cnt <= '0;
      digit   <= '0;
    end else if (compare_load) begin
      compare <= compare_in;
      sec_cnt <= '0;
    end else if (sec_cnt >= compare) begin
      sec_cnt <= '0;
      digit   <= digit == 4'd9 ? 4'd0 : digit + 4'd1;
    end else
      sec_cnt <= sec_cnt + 1'b1;

  assign led_oeb = 7'b0000000;

  seven_seg_decoder u_dec (
    .digit   (digit),
    .segments(led_out)
  );
endmodule

// File: tb/tb_seven_segment_seconds.sv
// tb_seven_segment_seconds: directed self-checking bench for seven_segment_seconds
module tb_seven_segment_seconds;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] compare_in;
  logic        compare_load;
  logic [6:0]  led_out;
  logic [6:0]  led_oeb;
  logic [3:0]  digit;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [6:0]  exp_seg [10];

  seven_segment_seconds dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .compare_in  (compare_in),
    .compare_load(compare_load),
    .led_out     (led_out),
    .led_oeb     (led_oeb),
    .digit       (digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [23:0] v);
    compare_in   = v;
    compare_load = 1'b1;
    tick(1);
    compare_load = 1'b0;
  endtask

  initial begin
    exp_seg = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};
    reset_n = 1'b0;
    compare_in = '0;
    compare_load = 1'b0;
    tick(4);
    check("rst_led", led_out, 7'b0111111);
    check("rst_digit", digit, 0);
    check("rst_oeb", led_oeb, 0);
    check("rst_compare", dut.compare, 24'd15_999_999);
    reset_n = 1'b1;
    load(24'd99);
    for (int k = 1; k <= 10; k++) begin
      tick(99);
      check($sformatf("seq_hold_%0d", k), digit, (k - 1) % 10);
      tick(1);
      check($sformatf("seq_digit_%0d", k), digit, k % 10);
      check($sformatf("seq_led_%0d", k), led_out, exp_seg[k % 10]);
    end
    load(24'd0);
    tick(9);
    check("c0_nine", digit, 9);
    check("c0_nine_led", led_out, 7'b1100111);
    tick(1);
    check("c0_wrap", digit, 0);
    load(24'd1000);
    tick(500);
    check("shrink_mid", digit, 0);
    load(24'd10);
    tick(10);
    check("shrink_hold", digit, 0);
    tick(1);
    check("shrink_step", digit, 1);
    tick(66);
    check("pre_rst_digit", digit, 7);
    tick(5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("midrst_digit", digit, 0);
    check("midrst_led", led_out, 7'b0111111);
    check("midrst_compare", dut.compare, 24'd15_999_999);
    check("midrst_cnt", dut.sec_cnt, 0);
    tick(20);
    check("midrst_hold", digit, 0);
    load(24'd5);
    tick(5);
    check("coll_pre", digit, 0);
    load(24'd5);
    check("coll_digit", digit, 0);
    check("coll_cnt", dut.sec_cnt, 0);
    tick(5);
    check("coll_hold", digit, 0);
    tick(1);
    check("coll_step", digit, 1);
    check("coll_led", led_out, 7'b0000110);
    for (int v = 10; v < 16; v++) begin
      logic [3:0] d;
      d = 4'(v);
      check($sformatf("blank_%0d", v), seven_seg_pkg::seg_decode(d), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_segment_seconds.md
# seven_segment_seconds

User-area seconds counter that drives a single common-cathode seven-segment digit on the Caravel user I/O pads. A prescaler divides the user clock to a one-tick-per-"second" enable. A decimal digit counter advances 0→9→0 on each tick. The decoded segment pattern drives mprj_io[6:0]; firmware sets the prescaler compare value over a simple load port.

## Interface
Parameters:
- COUNT_W, 24 — width of prescaler counter and compare register.
- DEFAULT_COMPARE, 24'd15_999_999 — compare value after reset (1 s at 16 MHz).

Ports:
- clk  in  1  user clock (wb_clk_i from the wrapper); all state on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
- compare_in  in  COUNT_W  new prescaler compare value.
- compare_load  in  1  when high, compare_in is captured this cycle.
- led_out  out  7  segments {g,f,e,d,c,b,a}, 1 = lit; mapped to mprj_io[6:0].
- led_oeb  out  7  pad output-enable bar, constant 7'b0000000.
- digit  out  4  current decimal value 0–9 (debug/observability).

## Operation
- Registers: compare (COUNT_W), sec_cnt (COUNT_W), digit (4).
- Reset (reset_n=0 at edge): compare←DEFAULT_COMPARE, sec_cnt←0, digit←0.
- compare_load=1: compare←compare_in; sec_cnt←0 that cycle (restart period).
- Otherwise, if sec_cnt >= compare: sec_cnt←0, digit←(digit==9)?0:digit+1; else sec_cnt←sec_cnt+1.
- The >= compare is deliberate. A counter already above a smaller compare wraps on the next edge and never overruns.
- Tick period = compare+1 clocks. compare=0 advances the digit every clock.
- Decoder (combinational from digit): 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110, 5→1101101, 6→1111100, 7→0000111, 8→1111111, 9→1100111.
- The 6 (top segment off) and 9 (bottom segment off) glyphs are required exactly as listed.
- digit values 10–15 are unreachable. The decoder emits 0000000 for them.
- led_oeb is tied low, so all seven pads are always outputs.

## Timing
- Reset values: led_out=0111111, digit=0, led_oeb=0000000.
- led_out changes in the same cycle as digit; no extra pipeline stage.
- First increment happens compare+1 edges after reset release or after a load.
- Full cycle 0→9→0 = 10·(compare+1) clocks.
- Reset has priority over compare_load, which has priority over counting.
- Reset asserted mid-period forces digit 0 and discards the partial count.

## Structure
- Shared package seven_seg_pkg holds:
  - SEG_0…SEG_9 constants and SEG_BLANK;
  - a function seg_decode(input [3:0]) returning 7 bits;
  - the COUNT_W default.
- Natural sub-module: seven_seg_decoder (pure combinational digit→segments).
- The top file holds the prescaler, digit counter and compare register.
- The wrapper drives io_out[6:0]=led_out and io_oeb[6:0]=led_oeb, and connects compare_in/compare_load to a firmware-writable register (e.g. la_data_in and a la_oenb strobe).

## Test plan
- Reset: hold reset_n=0 for 4 clocks → led_out=0111111, digit=0, led_oeb=0. Then release.
- Full sequence: load compare=99 → exactly one digit step every 100 clocks. Check led_out walks 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111100, 0000111, 1111111, 1100111, then returns to 0111111 at clock 1000.
- Compare=0: digit advances every clock. 9→0 wrap occurs on the 10th clock after load.
- Shrink mid-count: compare=1000, run 500 clocks, load compare=10 → digit steps 11 clocks after load.
- Reset mid-operation: at digit=7, reset_n=0 for one edge → next cycle digit=0, led_out=0111111, compare=DEFAULT_COMPARE.
- Load vs. tick collision: assert compare_load on the cycle sec_cnt==compare → no digit increment; period restarts from 0.
